// File: rtl/clkdiv_multi.sv
// Bank of NUM_CH soft clock dividers: programmable ratio, reload at the period boundary,
// per-channel phase slip (calib) and global realign (sync). Define CLKDIV_LOCK_EN for the lock output.
module clkdiv_multi #(
  parameter  int NUM_CH      = 2,
  parameter  int DIV_W       = 8,
  parameter  int MAX_DIV     = 255,
  parameter  int DEFAULT_DIV = 5,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              hclkin,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              sync,
  input  logic [NUM_CH-1:0] calib,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] div_out
`ifdef CLKDIV_LOCK_EN
  ,
  output logic [NUM_CH-1:0] lock
`endif
);

  // state   | meaning
  // ST_IDLE | in reset or on the first edge after it; counters load 0 so the first pulse follows release
  // ST_RUN  | channels count, reload, slip and realign
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("clkdiv_multi: NUM_CH must be 1..8");
  end
  if (MAX_DIV < 1 || MAX_DIV >= (2 ** DIV_W)) begin : g_bad_max_div
    $error("clkdiv_multi: MAX_DIV must be 1..2^DIV_W-1");
  end
  if (DEFAULT_DIV < 1 || DEFAULT_DIV > MAX_DIV) begin : g_bad_default_div
    $error("clkdiv_multi: DEFAULT_DIV must be 1..MAX_DIV");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_run;
  logic [NUM_CH-1:0] w_pending;
  logic              w_sel_pending;
  logic              w_xfer;
  logic              w_div_legal;
  logic              r_cfg_err;

  always_ff @(posedge hclkin) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // A channel index beyond NUM_CH reads as pending, so it can never handshake.
  always_comb begin
    w_sel_pending = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        w_sel_pending = w_pending[i];
      end
    end
  end

  assign cfg_ready   = !w_sel_pending;
  assign w_xfer      = cfg_valid && cfg_ready;
  assign w_div_legal = (cfg_div != '0) && ({1'b0, cfg_div} <= (DIV_W + 1)'(MAX_DIV));

  always_ff @(posedge hclkin) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_div_legal;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_ce;
    logic             r_dout;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_shadow_nxt;
    logic [DIV_W:0]   w_half_nxt;
    logic             w_pend_nxt;
    logic             w_wrap;
    logic             w_apply;
    logic             w_wr;

    assign w_wr   = w_xfer && w_div_legal && (cfg_ch == CH_W'(g));
    assign w_wrap = (r_cnt == r_div - 1'b1);

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_apply   = 1'b0;
      if (!w_run) begin
        w_cnt_nxt = '0;
      end else if (sync) begin
        w_cnt_nxt = '0;
        w_apply   = r_pend;
      end else if (calib[g]) begin
        w_cnt_nxt = r_cnt;
      end else if (w_wrap) begin
        w_cnt_nxt = '0;
        w_apply   = r_pend;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    // Writes only land while not pending and applies only happen while pending, so they never collide.
    assign w_div_nxt    = w_apply ? r_shadow : r_div;
    assign w_pend_nxt   = w_wr || (r_pend && !w_apply);
    assign w_shadow_nxt = w_wr ? cfg_div : r_shadow;
    assign w_half_nxt   = ({1'b0, w_div_nxt} + 1'b1) >> 1;

    // Outputs are registered from the next count so they line up with the cnt they describe.
    always_ff @(posedge hclkin) begin
      if (reset) begin
        r_cnt    <= '0;
        r_div    <= DIV_W'(DEFAULT_DIV);
        r_shadow <= DIV_W'(DEFAULT_DIV);
        r_pend   <= 1'b0;
        r_ce     <= 1'b0;
        r_dout   <= 1'b0;
      end else begin
        r_cnt    <= w_cnt_nxt;
        r_div    <= w_div_nxt;
        r_shadow <= w_shadow_nxt;
        r_pend   <= w_pend_nxt;
        r_ce     <= (w_cnt_nxt == '0);
        r_dout   <= ({1'b0, w_cnt_nxt} < w_half_nxt);
      end
    end

    assign w_pending[g] = r_pend;
    assign ce_out[g]    = r_ce;
    assign div_out[g]   = r_dout;

`ifdef CLKDIV_LOCK_EN
    logic r_seen_wrap;
    logic r_lock;
    logic w_lock_clr;
    logic w_count_wrap;

    assign w_lock_clr   = w_run && (sync || calib[g] || w_apply);
    assign w_count_wrap = w_run && w_wrap && !sync && !calib[g];

    always_ff @(posedge hclkin) begin
      if (reset) begin
        r_seen_wrap <= 1'b0;
        r_lock      <= 1'b0;
      end else if (w_lock_clr) begin
        r_seen_wrap <= 1'b0;
        r_lock      <= 1'b0;
      end else if (w_count_wrap) begin
        if (r_seen_wrap) begin
          r_lock <= 1'b1;
        end
        r_seen_wrap <= 1'b1;
      end
    end

    assign lock[g] = r_lock;
`endif
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: reference model feeds a scoreboard queue each cycle,
// plus hand-derived checks for reload, error, calib, sync, reset and divisor boundaries.
module tb_clkdiv_multi;
  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int MAX_DIV     = 200;
  localparam int DEFAULT_DIV = 5;

  logic              hclkin    = 1'b0;
  logic              reset     = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [0:0]        cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
  logic              sync      = 1'b0;
  logic [NUM_CH-1:0] calib     = '0;
  wire               cfg_ready;
  wire               cfg_err;
  wire [NUM_CH-1:0]  ce_out;
  wire [NUM_CH-1:0]  div_out;
`ifdef CLKDIV_LOCK_EN
  wire [NUM_CH-1:0]  lock;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] dout;
    logic              err;
    logic [NUM_CH-1:0] lk;
  } exp_t;

  exp_t sb_q[$];

  int m_cnt    [NUM_CH];
  int m_div    [NUM_CH];
  int m_shadow [NUM_CH];
  int m_wraps  [NUM_CH];
  bit m_pend   [NUM_CH];
  bit m_lock   [NUM_CH];
  bit m_started = 1'b0;
  bit m_known   = 1'b0;

  clkdiv_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .MAX_DIV     (MAX_DIV),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .hclkin    (hclkin),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .sync      (sync),
    .calib     (calib),
    .ce_out    (ce_out),
    .div_out   (div_out)
`ifdef CLKDIV_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 hclkin = ~hclkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    bit xfer, legal, clr, wrap, apply;
    e = '0;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i]    = 0;
        m_div[i]    = DEFAULT_DIV;
        m_shadow[i] = DEFAULT_DIV;
        m_pend[i]   = 1'b0;
        m_wraps[i]  = 0;
        m_lock[i]   = 1'b0;
      end
      m_started = 1'b0;
      m_known   = 1'b1;
      return;
    end
    xfer  = cfg_valid && !m_pend[cfg_ch];
    legal = (cfg_div != 0) && (cfg_div <= MAX_DIV);
    e.err = xfer && !legal;
    for (int i = 0; i < NUM_CH; i++) begin
      clr = 1'b0; wrap = 1'b0; apply = 1'b0;
      if (!m_started) begin
        m_cnt[i] = 0;
      end else if (sync) begin
        m_cnt[i] = 0; apply = m_pend[i]; clr = 1'b1;
      end else if (calib[i]) begin
        clr = 1'b1;
      end else if (m_cnt[i] == m_div[i] - 1) begin
        m_cnt[i] = 0; wrap = 1'b1; apply = m_pend[i];
      end else begin
        m_cnt[i]++;
      end
      if (apply) begin
        m_div[i] = m_shadow[i]; m_pend[i] = 1'b0; clr = 1'b1;
      end
      if (clr) begin
        m_wraps[i] = 0; m_lock[i] = 1'b0;
      end else if (wrap) begin
        m_wraps[i]++;
        if (m_wraps[i] >= 2) m_lock[i] = 1'b1;
      end
      if (xfer && legal && (cfg_ch == i)) begin
        m_shadow[i] = cfg_div; m_pend[i] = 1'b1;
      end
      e.ce[i]   = (m_cnt[i] == 0);
      e.dout[i] = (m_cnt[i] < (m_div[i] + 1) / 2);
      e.lk[i]   = m_lock[i];
    end
    m_started = 1'b1;
  endtask

  task automatic cycle();
    exp_t e;
    #1;
    if (m_known) check("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
    model_step(e);
    sb_q.push_back(e);
    @(posedge hclkin);
    #1;
    e = sb_q.pop_front();
    check("ce_out", ce_out, e.ce);
    check("div_out", div_out, e.dout);
    check("cfg_err", cfg_err, e.err);
`ifdef CLKDIV_LOCK_EN
    check("lock", lock, e.lk);
`endif
  endtask

  task automatic wait_ce(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ce_out[ch] !== 1'b1 && n < 400);
    check("wait_ce_seen", ce_out[ch], 1'b1);
  endtask

  initial begin
    logic [9:0] ce_seq, dv_seq;
    int n, errs;

    // 1: reset state and default divide-by-5
    reset = 1'b1;
    repeat (3) cycle();
    check("rst_ready", cfg_ready, 1'b1);
    reset = 1'b0;
    ce_seq = '0; dv_seq = '0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (k <= 10) begin
        ce_seq = {ce_seq[8:0], ce_out[0]};
        dv_seq = {dv_seq[8:0], div_out[0]};
      end
    end
    check("t1_ce0_seq", ce_seq, 10'b1000010000);
    check("t1_dv0_seq", dv_seq, 10'b1110011100);

    // 2: reload ch1 to 4 mid-period (cycle 22, cnt=1)
    cycle(); cycle();
    cfg_ch = 1'b1; cfg_div = 8'd4; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    #1 check("t2_ready_low_a", cfg_ready, 1'b0);
    cycle();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    #1 check("t2_ready_low_b", cfg_ready, 1'b0);
    cycle();
    cfg_valid = 1'b0;
    #1 check("t2_ready_low_c", cfg_ready, 1'b0);
    cycle();
    #1 check("t2_ready_high", cfg_ready, 1'b1);
    ce_seq = {2'b00, 7'b0, ce_out[1]}; dv_seq = {2'b00, 7'b0, div_out[1]};
    for (int k = 0; k < 7; k++) begin
      cycle();
      ce_seq = {ce_seq[8:0], ce_out[1]};
      dv_seq = {dv_seq[8:0], div_out[1]};
    end
    check("t2_ce1_seq", ce_seq[7:0], 8'b10001000);
    check("t2_dv1_seq", dv_seq[7:0], 8'b11001100);

    // 3: illegal divisors 0 and MAX_DIV+1
    errs = 0;
    cfg_ch = 1'b0; cfg_div = 8'd0; cfg_valid = 1'b1;
    cycle(); errs += int'(cfg_err);
    cfg_div = 8'(MAX_DIV + 1);
    cycle(); errs += int'(cfg_err);
    cfg_valid = 1'b0;
    cycle(); errs += int'(cfg_err);
    check("t3_err_pulses", errs, 2);
    #1 check("t3_ready", cfg_ready, 1'b1);
    wait_ce(0, n);
    check("t3_ch0_period", n, 5);

    // 4: two calib cycles at cnt=2 stretch ch0's period to 7
    cycle(); cycle();
    calib = 2'b01;
    cycle(); cycle();
    calib = 2'b00;
    wait_ce(0, n);
    check("t4_ch0_period", 4 + n, 7);

    // 5: sync with ch1 reload to 3 pending and calib[1] together
    cfg_ch = 1'b1; cfg_div = 8'd3; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0; sync = 1'b1; calib = 2'b10;
    cycle();
    sync = 1'b0; calib = 2'b00;
    check("t5_ce_all", ce_out, 2'b11);
    ce_seq = {9'b0, ce_out[1]}; dv_seq = {9'b0, div_out[1]};
    for (int k = 0; k < 5; k++) begin
      cycle();
      ce_seq = {ce_seq[8:0], ce_out[1]};
      dv_seq = {dv_seq[8:0], div_out[1]};
    end
    check("t5_ce1_seq", ce_seq[5:0], 6'b100100);
    check("t5_dv1_seq", dv_seq[5:0], 6'b110110);
    #1 check("t5_ready", cfg_ready, 1'b1);

    // 6: lock after two wraps, drop on calib, reset mid-reload
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      cycle();
`ifdef CLKDIV_LOCK_EN
      if (k == 10) check("t6_lock_early", lock, 2'b00);
      if (k == 11) check("t6_lock_set", lock, 2'b11);
`endif
    end
    calib = 2'b01;
    cycle();
    calib = 2'b00;
`ifdef CLKDIV_LOCK_EN
    check("t6_lock_calib", lock, 2'b10);
`endif
    cfg_ch = 1'b0; cfg_div = 8'd7; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    #1 check("t6_pending", cfg_ready, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1 check("t6_ready_after_rst", cfg_ready, 1'b1);
    cycle();
    check("t6_first_ce", ce_out, 2'b11);
    wait_ce(0, n);
    check("t6_ch0_period", n, 5);
`ifdef CLKDIV_LOCK_EN
    check("t6_lock_rst", lock, 2'b00);
`endif

    // 7: divisor boundaries 1 and MAX_DIV
    cfg_ch = 1'b0; cfg_div = 8'd1; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0; sync = 1'b1;
    cycle();
    sync = 1'b0;
    ce_seq = '0; dv_seq = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      ce_seq = {ce_seq[8:0], ce_out[0]};
      dv_seq = {dv_seq[8:0], div_out[0]};
    end
    check("t7_div1_ce", ce_seq[3:0], 4'b1111);
    check("t7_div1_dv", dv_seq[3:0], 4'b1111);
    cfg_ch = 1'b1; cfg_div = 8'(MAX_DIV); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    #1 check("t7_max_accepted", cfg_ready, 1'b0);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    wait_ce(1, n);
    check("t7_max_period", n, MAX_DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised soft clock-divider bank that replaces fixed-ratio hard CLKDIV primitives. Runs in the fabric on a single fast clock and generates NUM_CH independent divided enables and square waves. Each channel has a runtime-programmable ratio, a glitch-free reload at the period boundary, a per-channel one-cycle phase slip (calib) and a global realign (sync). It feeds clock-enables to the DDR3 user logic and the video pipeline stages.

Parameters:
NUM_CH, 2, number of divider channels (1..8)
DIV_W, 8, divisor width; legal divisor range is 1..MAX_DIV
MAX_DIV, 255, largest accepted divisor (must be less than 2^DIV_W)
DEFAULT_DIV, 5, divisor loaded into every channel at reset

Ports:
hclkin  in  1  fast source clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  reload request
cfg_ready  out  1  combinational; equals !pending[cfg_ch]
cfg_ch  in  clog2(NUM_CH) (min 1)  target channel
cfg_div  in  DIV_W  new divisor
cfg_err  out  1  one-cycle pulse when a handshake carries an illegal divisor
sync  in  1  realign all channels
calib  in  NUM_CH  per-channel phase-slip request
ce_out  out  NUM_CH  one-cycle enable per period
div_out  out  NUM_CH  divided square wave

Behaviour:
- Clocking and reset: one clock, hclkin. Reset is synchronous and active-high.
- Reset values: cnt=0, div=DEFAULT_DIV and pending=0 on every channel. ce_out=0, div_out=0, cfg_err=0.
- All outputs except cfg_ready are registered.
- Counter per channel: cnt runs 0..div-1 and then wraps to 0.
- Output timing:
  - ce_out[i]=1 exactly in the cycles where cnt[i]==0.
  - div_out[i]=1 while cnt[i] < ceil(div/2). Even divisors give 50% duty; odd divisors have the high phase one cycle longer.
  - div=1 gives ce_out and div_out constantly high.
- First pulse after reset: appears in the first cycle after the first edge that samples reset low. Later pulses follow every div cycles.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - If cfg_div is 0 or greater than MAX_DIV: the request is dropped, cfg_err pulses in the next cycle, and pending is unchanged.
  - Otherwise cfg_div is written to shadow[cfg_ch] and pending[cfg_ch] is set.
  - cfg_valid while ready is low: no effect. The requester holds the request.
- Reload: a pending shadow is copied to div on the next wrap (cnt div-1 -> 0) strictly after the accepting edge, and pending is cleared on that edge. A request accepted on a wrap edge therefore applies at the following wrap. The period in progress always completes with the old divisor, so there are no runt pulses.
- calib[i]=1: channel i holds cnt for one cycle, stretching the current period to div+1. N consecutive calib cycles stretch it by N. Outputs follow cnt, so a held cycle repeats its output values.
- sync=1: every cnt is forced to 0 at that edge, and all pending shadows are applied at that edge. The next cycle has ce_out all ones.
- Priority: reset > sync > calib > normal count.
- Reset mid-reload: pending is dropped and div reverts to DEFAULT_DIV.

Optional Feature:
CLKDIV_LOCK_EN
- Defined: adds output lock (NUM_CH, registered, reset 0).
  - lock[i] clears on reset, sync, calib[i], or application of a reload to channel i.
  - lock[i] sets after two complete undisturbed periods, i.e. at the second wrap after the clearing event.
- Undefined: the lock port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then run 20 cycles with the defaults -> ce_out[0] high every 5th cycle starting in cycle 1 after release; div_out pattern 1,1,1,0,0 repeating.
2. Write cfg_ch=1, cfg_div=4 mid-period -> channel 1 completes its 5-cycle period, then runs 1,1,0,0 with ce every 4; channel 0 is unaffected; cfg_ready[ch1] is low until the wrap.
3. Write cfg_div=0, then cfg_div=MAX_DIV+1 (MAX_DIV=200) -> two cfg_err pulses; divisor stays 5; pending stays 0.
4. Pulse calib[0] for 2 cycles at cnt=2 -> that period lasts 7 cycles; channel 1 keeps its phase.
5. Assert sync while channel 1 has a pending reload to 3 and sync and calib[1] are asserted together -> both cnt are 0 next cycle, ce_out=2'b11, channel 1 runs div 3, calib is ignored.
6. With CLKDIV_LOCK_EN defined: lock rises at the second wrap after reset and drops on calib; assert reset mid-reload -> divisor returns to 5 and lock is 0.
